imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_array.sv | 25 ++
 rtl/imem_responder.sv | 145 ++++++++++++++
 tb/tb_imem_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and state encoding for the instruction memory responder
package imem_pkg;

  localparam int WAIT_STATES_DEF = 2;
  localparam int DEPTH_LOG2_DEF  = 8;

  localparam logic [15:0] ZERO = 16'h0000;
  localparam logic [15:0] NOP  = ZERO;

  typedef logic [1:0] imem_state_t;

  localparam imem_state_t IDLE = 2'd0;
  localparam imem_state_t WAIT = 2'd1;
  localparam imem_state_t RESP = 2'd2;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - synchronous word RAM with registered read and write-first collision behaviour
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [15:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [15:0]           rdata
);

  // Power-up contents are NOP; reset deliberately leaves the program image alone.
  logic [15:0] mem [0:(1 << DEPTH_LOG2) - 1] = '{default: NOP};

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fetch-side memory responder with wait states; IMEM_PREFETCH_EN adds a next-word prefetch buffer
module imem_responder
  import imem_pkg::*;
#(
  parameter int WAIT_STATES = WAIT_STATES_DEF,
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  input  logic [15:0] RADDR_CPU,
  output logic        REQ_READY,
  output logic        RESP_VALID,
  output logic [15:0] DATA_OUT,
  input  logic        LOAD_EN,
  input  logic [15:0] LOAD_ADDR,
  input  logic [15:0] LOAD_DATA,
  output logic        BUSY
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  imem_state_t           state;
  logic [3:0]            wait_cnt;
  logic [15:0]           addr_reg;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [15:0]           rdata;
  logic [15:0]           resp_word;
  logic                  hs;
  logic                  go_fast;
  logic                  load_hit_cur;

  assign REQ_READY    = !RST && !LOAD_EN && ((state == IDLE) || (state == RESP));
  assign hs           = REQ_VALID && REQ_READY;
  assign BUSY         = (state != IDLE);
  assign load_hit_cur = LOAD_EN && (LOAD_ADDR[DEPTH_LOG2-1:0] == addr_reg[DEPTH_LOG2-1:0]);

  logic unused_hi_bits;
  assign unused_hi_bits = ^{addr_reg[15:DEPTH_LOG2], LOAD_ADDR[15:DEPTH_LOG2]};

`ifdef IMEM_PREFETCH_EN
  logic [15:0] addr_next;
  logic [15:0] pf_addr;
  logic [15:0] pf_data;
  logic        pf_tag_ok;
  logic        pf_data_ok;
  logic        pf_fill;
  logic        pf_from_buf;

  assign addr_next = addr_reg + 16'd1;
  assign go_fast   = pf_tag_ok && (RADDR_CPU == pf_addr);
  // The RESP-cycle read port is free, so it fetches addr+1 for the buffer.
  assign rd_idx    = hs ? RADDR_CPU[DEPTH_LOG2-1:0]
                   : (state == RESP) ? addr_next[DEPTH_LOG2-1:0]
                   : addr_reg[DEPTH_LOG2-1:0];
  assign resp_word = load_hit_cur ? LOAD_DATA : (pf_from_buf ? pf_data : rdata);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pf_addr     <= ZERO;
      pf_data     <= ZERO;
      pf_tag_ok   <= 1'b0;
      pf_data_ok  <= 1'b0;
      pf_fill     <= 1'b0;
      pf_from_buf <= 1'b0;
    end else begin
      pf_fill     <= (state == RESP) && !hs;
      pf_from_buf <= hs && go_fast && pf_data_ok;
      if (state == RESP) begin
        pf_addr    <= addr_next;
        pf_tag_ok  <= !(LOAD_EN && (LOAD_ADDR[DEPTH_LOG2-1:0] == addr_next[DEPTH_LOG2-1:0]));
        pf_data_ok <= 1'b0;
      end else if (LOAD_EN && (LOAD_ADDR[DEPTH_LOG2-1:0] == pf_addr[DEPTH_LOG2-1:0])) begin
        pf_tag_ok  <= 1'b0;
        pf_data_ok <= 1'b0;
      end else if (pf_fill) begin
        pf_data    <= rdata;
        pf_data_ok <= pf_tag_ok;
      end
    end
  end
`else
  assign go_fast   = 1'b0;
  assign rd_idx    = hs ? RADDR_CPU[DEPTH_LOG2-1:0] : addr_reg[DEPTH_LOG2-1:0];
  assign resp_word = load_hit_cur ? LOAD_DATA : rdata;
`endif

  imem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .CLK  (CLK),
    .we   (LOAD_EN),
    .waddr(LOAD_ADDR[DEPTH_LOG2-1:0]),
    .wdata(LOAD_DATA),
    .raddr(rd_idx),
    .rdata(rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      addr_reg <= ZERO;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (hs) begin
            addr_reg <= RADDR_CPU;
            if ((WAIT_STATES == 0) || go_fast) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response is registered out of the RESP cycle, so a load landing in that cycle is forwarded.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RESP_VALID <= 1'b0;
      DATA_OUT   <= NOP;
    end else if (state == RESP) begin
      RESP_VALID <= 1'b1;
      DATA_OUT   <= resp_word;
    end else begin
      RESP_VALID <= 1'b0;
      DATA_OUT   <= NOP;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - checks two responder instances (0 and 2 wait states) against a request-level model
module tb_imem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        req_valid[2];
  logic        load_en[2];
  logic [15:0] raddr[2];
  logic [15:0] load_addr[2];
  logic [15:0] load_data[2];
  logic        req_ready[2];
  logic        resp_valid[2];
  logic        busy[2];
  logic [15:0] data_out[2];

  imem_responder #(.WAIT_STATES(0), .DEPTH_LOG2(8)) u_ws0 (
    .CLK(clk), .RST(rst[0]), .REQ_VALID(req_valid[0]), .RADDR_CPU(raddr[0]),
    .REQ_READY(req_ready[0]), .RESP_VALID(resp_valid[0]), .DATA_OUT(data_out[0]),
    .LOAD_EN(load_en[0]), .LOAD_ADDR(load_addr[0]), .LOAD_DATA(load_data[0]), .BUSY(busy[0])
  );

  imem_responder #(.WAIT_STATES(2), .DEPTH_LOG2(8)) u_ws2 (
    .CLK(clk), .RST(rst[1]), .REQ_VALID(req_valid[1]), .RADDR_CPU(raddr[1]),
    .REQ_READY(req_ready[1]), .RESP_VALID(resp_valid[1]), .DATA_OUT(data_out[1]),
    .LOAD_EN(load_en[1]), .LOAD_ADDR(load_addr[1]), .LOAD_DATA(load_data[1]), .BUSY(busy[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[u%0d] @%0t: got %0h want %0h", name, i, $time, act, exp);
    end
  endtask

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  // Request-level model: edges remaining until a response, a shadow word array, prefetch tag.
  int          pend[2];
  logic [15:0] m_addr[2];
  logic [15:0] mmem[2][256];
  logic        m_pf_ok[2];
  logic [15:0] m_pf_addr[2];
  logic        exp_valid[2];
  logic [15:0] exp_data[2];
  logic        live = 1'b0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; m_addr[i] = 16'h0; m_pf_ok[i] = 1'b0; m_pf_addr[i] = 16'h0;
      exp_valid[i] = 1'b0; exp_data[i] = 16'h0;
      for (int k = 0; k < 256; k++) mmem[i][k] = 16'h0000;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic rdy;
      logic take;
      logic hit;
      rdy  = !rst[i] && !load_en[i] && (pend[i] <= 1);
      take = req_valid[i] && rdy;
      hit  = 1'b0;
`ifdef IMEM_PREFETCH_EN
      hit = m_pf_ok[i] && (raddr[i] == m_pf_addr[i]);
`endif
      if (load_en[i]) mmem[i][load_addr[i] % 256] = load_data[i];
      if (rst[i]) begin
        pend[i] = 0; exp_valid[i] = 1'b0; exp_data[i] = 16'h0000; m_pf_ok[i] = 1'b0;
      end else begin
        exp_valid[i] = (pend[i] == 1);
        exp_data[i]  = (pend[i] == 1) ? mmem[i][m_addr[i] % 256] : 16'h0000;
        if (pend[i] == 1) begin
          m_pf_addr[i] = m_addr[i] + 16'd1;
          m_pf_ok[i]   = 1'b1;
        end
        if (load_en[i] && ((load_addr[i] % 256) == (m_pf_addr[i] % 256))) m_pf_ok[i] = 1'b0;
        if (pend[i] > 0) pend[i]--;
        if (take) begin
          m_addr[i] = raddr[i];
          pend[i]   = hit ? 1 : ws_of(i) + 1;
        end
      end
    end
    live = 1'b1;
  end

  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < 2; i++) begin
        cmp("resp_valid", i, resp_valid[i], exp_valid[i]);
        cmp("data_out", i, data_out[i], exp_data[i]);
        cmp("busy", i, busy[i], pend[i] > 0);
        cmp("req_ready", i, req_ready[i], !rst[i] && !load_en[i] && (pend[i] <= 1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int i, input logic [15:0] a, input logic [15:0] d);
    load_en[i] = 1'b1; load_addr[i] = a; load_data[i] = d;
    tick();
    load_en[i] = 1'b0;
  endtask

  task automatic start_req(input int i, input logic [15:0] a);
    bit ok = 1'b0;
    req_valid[i] = 1'b1;
    raddr[i] = a;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready[i];
      tick();
    end
    req_valid[i] = 1'b0;
    cmp("handshake", i, ok, 1);
  endtask

  task automatic wait_resp(input int i, output int lat, output logic [15:0] d);
    bit got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      got = resp_valid[i];
    end
    d = data_out[i];
    cmp("resp_seen", i, got, 1);
  endtask

  task automatic request(input int i, input logic [15:0] a, output int lat, output logic [15:0] d);
    start_req(i, a);
    wait_resp(i, lat, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [15:0] d;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; load_en[i] = 1'b0;
      raddr[i] = 16'h0; load_addr[i] = 16'h0; load_data[i] = 16'h0;
    end
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cmp("rst_resp_valid", i, resp_valid[i], 0);
      cmp("rst_data_out", i, data_out[i], 0);
      cmp("rst_busy", i, busy[i], 0);
      cmp("rst_req_ready", i, req_ready[i], 0);
    end
    tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    cmp("ready_after_rst", 0, req_ready[0], 1);
    cmp("ready_after_rst", 1, req_ready[1], 1);
    tick();

    load(1, 16'h0005, 16'h1234);
    request(1, 16'h0005, lat, d);
    cmp("ws2_latency", 1, lat, 3);
    cmp("ws2_data", 1, d, 16'h1234);

    request(1, 16'h0105, lat, d);
    cmp("wrap_data", 1, d, 16'h1234);

    load(0, 16'h0010, 16'hA010);
    load(0, 16'h0011, 16'hA011);
    req_valid[0] = 1'b1; raddr[0] = 16'h0010;
    @(negedge clk);
    cmp("b2b_ready_a", 0, req_ready[0], 1);
    tick();
    raddr[0] = 16'h0011;
    @(negedge clk);
    cmp("b2b_ready_b", 0, req_ready[0], 1);
    tick();
    req_valid[0] = 1'b0;
    cmp("b2b_valid_a", 0, resp_valid[0], 1);
    cmp("b2b_data_a", 0, data_out[0], 16'hA010);
    tick();
    cmp("b2b_valid_b", 0, resp_valid[0], 1);
    cmp("b2b_data_b", 0, data_out[0], 16'hA011);
    tick();

    start_req(1, 16'h0020);
    load_en[1] = 1'b1; load_addr[1] = 16'h0020; load_data[1] = 16'hBEEF;
    tick();
    load_en[1] = 1'b0;
    wait_resp(1, lat, d);
    cmp("fwd_wait_data", 1, d, 16'hBEEF);
    cmp("fwd_wait_lat", 1, lat, 2);

    request(1, 16'h0077, lat, d);
    cmp("uninit_data", 1, d, 16'h0000);

    start_req(1, 16'h0023);
    tick();
    tick();
    load_en[1] = 1'b1; load_addr[1] = 16'h0023; load_data[1] = 16'hC0DE;
    tick();
    load_en[1] = 1'b0;
    cmp("fwd_resp_valid", 1, resp_valid[1], 1);
    cmp("fwd_resp_data", 1, data_out[1], 16'hC0DE);
    tick();

    load_en[1] = 1'b1; load_addr[1] = 16'h0006; load_data[1] = 16'h0606;
    req_valid[1] = 1'b1; raddr[1] = 16'h0006;
    @(negedge clk);
    cmp("load_blocks_ready", 1, req_ready[1], 0);
    tick();
    load_en[1] = 1'b0;
    request(1, 16'h0006, lat, d);
    cmp("after_load_data", 1, d, 16'h0606);
    cmp("after_load_lat", 1, lat, 3);

    start_req(1, 16'h0005);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    @(negedge clk);
    cmp("rst_mid_ready", 1, req_ready[1], 1);
    for (int n = 0; n < 4; n++) begin
      tick();
      cmp("rst_mid_no_resp", 1, resp_valid[1], 0);
    end
    request(1, 16'h0005, lat, d);
    cmp("rst_keeps_array", 1, d, 16'h1234);

`ifdef IMEM_PREFETCH_EN
    load(1, 16'h0030, 16'h3030);
    load(1, 16'h0031, 16'h3131);
    load(1, 16'h0041, 16'h4141);
    request(1, 16'h0030, lat, d);
    cmp("pf_first_lat", 1, lat, 3);
    request(1, 16'h0031, lat, d);
    cmp("pf_seq_lat", 1, lat, 1);
    cmp("pf_seq_data", 1, d, 16'h3131);
    request(1, 16'h0040, lat, d);
    cmp("pf_miss_lat", 1, lat, 3);
    tick();
    request(1, 16'h0041, lat, d);
    cmp("pf_buf_lat", 1, lat, 1);
    cmp("pf_buf_data", 1, d, 16'h4141);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
